// File: rtl/mux16_rr_sched_if.sv
// Request/grant bundle between the requesters and the round-robin mux scheduler.
interface mux16_rr_sched_if;
  logic        en;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        el;
  logic        busy;

  modport master (output en, req, input gnt, sel, el, busy);
  modport slave  (input en, req, output gnt, sel, el, busy);
endinterface

// File: rtl/mux16_rr_sched.sv
// Round-robin owner of a shared 16:1 mux: bounded bursts, each followed by a
// programmable high-Z turnaround gap so the downstream bus drivers never overlap.
module mux16_rr_sched #(
  parameter int unsigned MAX_BEATS  = 8,
  parameter int unsigned GAP_CYCLES = 1
) (
  input logic             clk,
  input logic             rst,
  mux16_rr_sched_if.slave bus
);
  localparam int unsigned N  = 16;
  localparam int unsigned IW = 4;
  localparam int unsigned BW = 8;
  localparam int unsigned GW = 4;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel_q;
  logic [BW-1:0] beat;
  logic [GW-1:0] gap_cnt;
  logic [N-1:0]  gnt_q;
  logic          el_q;
  logic          busy_q;

  logic [IW:0]   win_cur;
  logic [IW:0]   win_nxt;
  logic [IW-1:0] nxt_ptr;
  logic          owner_done;

  // First set request at base, base+1, ... with wrap; MSB flags a hit.
  function automatic logic [IW:0] pick(input logic [N-1:0] r, input logic [IW-1:0] base);
    logic [IW:0]   res;
    logic [IW-1:0] idx;
    res = '0;
    for (int i = 15; i >= 0; i--) begin
      idx = base + IW'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // win_nxt uses the pointer as it will be once the current owner retires,
  // which is what a zero-gap back-to-back handover must arbitrate with.
  always_comb begin
    nxt_ptr    = sel_q + IW'(1);
    win_cur    = pick(bus.req, ptr);
    win_nxt    = pick(bus.req, nxt_ptr);
    owner_done = !bus.req[sel_q] || (beat == BW'(MAX_BEATS));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      sel_q   <= '0;
      beat    <= '0;
      gap_cnt <= '0;
      gnt_q   <= '0;
      el_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.en && win_cur[IW]) begin
            state  <= GRANT;
            gnt_q  <= N'(1) << win_cur[IW-1:0];
            sel_q  <= win_cur[IW-1:0];
            el_q   <= 1'b0;
            busy_q <= 1'b1;
            beat   <= BW'(1);
          end
        end
        GRANT: begin
          if (owner_done) begin
            ptr <= nxt_ptr;
            if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gnt_q   <= '0;
              el_q    <= 1'b1;
              gap_cnt <= GW'(1);
            end else if (bus.en && win_nxt[IW]) begin
              gnt_q <= N'(1) << win_nxt[IW-1:0];
              sel_q <= win_nxt[IW-1:0];
              beat  <= BW'(1);
            end else begin
              state  <= IDLE;
              gnt_q  <= '0;
              el_q   <= 1'b1;
              busy_q <= 1'b0;
            end
          end else begin
            beat <= beat + BW'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES)) begin
            if (bus.en && win_cur[IW]) begin
              state <= GRANT;
              gnt_q <= N'(1) << win_cur[IW-1:0];
              sel_q <= win_cur[IW-1:0];
              el_q  <= 1'b0;
              beat  <= BW'(1);
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.el   = el_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_mux16_rr_sched.sv
// Bench for mux16_rr_sched: three parameterisations checked every cycle against
// an owner/burst/gap model, plus hand-computed directed expectations.
`timescale 1ns/1ps
module tb_mux16_rr_sched;
  localparam int NI = 3;
  localparam int MB [NI] = '{8, 2, 8};
  localparam int GC [NI] = '{1, 1, 0};

  logic        clk;
  logic        rst;
  logic [15:0] req_v [NI];
  logic        en_v  [NI];

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux16_rr_sched_if b0 ();
  mux16_rr_sched_if b1 ();
  mux16_rr_sched_if b2 ();

  assign b0.en = en_v[0];  assign b0.req = req_v[0];
  assign b1.en = en_v[1];  assign b1.req = req_v[1];
  assign b2.en = en_v[2];  assign b2.req = req_v[2];

  mux16_rr_sched #(.MAX_BEATS(8), .GAP_CYCLES(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  mux16_rr_sched #(.MAX_BEATS(2), .GAP_CYCLES(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  mux16_rr_sched #(.MAX_BEATS(8), .GAP_CYCLES(0)) u2 (.clk(clk), .rst(rst), .bus(b2));

  // Model: who owns the mux, for how long, and how much gap is left.
  int owner [NI];
  int held  [NI];
  int gapl  [NI];
  int ptr_m [NI];
  int msel  [NI];

  function automatic int pick_m(input logic [15:0] r, input int base);
    for (int i = 0; i < 16; i++)
      if (r[(base + i) % 16]) return (base + i) % 16;
    return -1;
  endfunction

  task automatic model_reset(input int k);
    owner[k] = -1; held[k] = 0; gapl[k] = 0; ptr_m[k] = 0; msel[k] = 0;
  endtask

  task automatic model_grant(input int k);
    int w;
    w = pick_m(req_v[k], ptr_m[k]);
    if (en_v[k] && w >= 0) begin
      owner[k] = w; held[k] = 1; msel[k] = w;
    end
  endtask

  task automatic model_step(input int k);
    if (owner[k] >= 0) begin
      if (!req_v[k][owner[k]] || held[k] == MB[k]) begin
        ptr_m[k] = (owner[k] + 1) % 16;
        owner[k] = -1;
        if (GC[k] > 0) gapl[k] = GC[k];
        else model_grant(k);
      end else begin
        held[k]++;
      end
    end else if (gapl[k] > 0) begin
      gapl[k]--;
      if (gapl[k] == 0) model_grant(k);
    end else begin
      model_grant(k);
    end
  endtask

  function automatic logic [31:0] exp_out(input int k);
    logic [15:0] g;
    logic        e;
    logic        b;
    g = (owner[k] >= 0) ? (16'h0001 << owner[k]) : 16'h0000;
    e = (owner[k] < 0);
    b = (owner[k] >= 0) || (gapl[k] > 0);
    return {10'b0, g, 4'(msel[k]), e, b};
  endfunction

  function automatic logic [31:0] act_out(input int k);
    case (k)
      0: return {10'b0, b0.gnt, b0.sel, b0.el, b0.busy};
      1: return {10'b0, b1.gnt, b1.sel, b1.el, b1.busy};
      default: return {10'b0, b2.gnt, b2.sel, b2.el, b2.busy};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) model_reset(k);
    forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < NI; k++)
        if (rst) model_reset(k);
        else model_step(k);
    end
  end

  // Per-cycle comparison of {gnt,sel,el,busy} against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst)
        for (int k = 0; k < NI; k++)
          check($sformatf("model_u%0d", k), act_out(k), exp_out(k));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      req_v[k] = '0;
      en_v[k]  = 1'b1;
    end
    rst = 1'b1;
    cyc(2);
    check("rst_gnt", 32'(b0.gnt), 32'h0);
    check("rst_el", 32'(b0.el), 32'h1);
    check("rst_busy", 32'(b0.busy), 32'h0);
    check("rst_sel", 32'(b0.sel), 32'h0);
    rst = 1'b0;
    cyc(2);

    // Single long request: 8 beats, 1 gap, sole requester re-granted.
    req_v[0] = 16'h0008;
    cyc(1);
    check("long_gnt", 32'(b0.gnt), 32'h0008);
    check("long_sel", 32'(b0.sel), 32'h3);
    check("long_el", 32'(b0.el), 32'h0);
    cyc(7);
    check("long_beat8", 32'(b0.gnt), 32'h0008);
    cyc(1);
    check("long_gap_gnt", 32'(b0.gnt), 32'h0);
    check("long_gap_el", 32'(b0.el), 32'h1);
    check("long_gap_busy", 32'(b0.busy), 32'h1);
    cyc(1);
    check("long_regrant", 32'(b0.gnt), 32'h0008);
    req_v[0] = '0;
    cyc(4);
    check("long_idle", 32'(b0.busy), 32'h0);

    // Asynchronous reset mid-grant: owner 5 at beat 3.
    req_v[0] = 16'h0020;
    cyc(3);
    check("pre_rst_gnt", 32'(b0.gnt), 32'h0020);
    #2 rst = 1'b1;
    #1;
    check("arst_gnt", 32'(b0.gnt), 32'h0);
    check("arst_el", 32'(b0.el), 32'h1);
    check("arst_busy", 32'(b0.busy), 32'h0);
    check("arst_sel", 32'(b0.sel), 32'h0);
    cyc(1);
    req_v[0] = '0;
    rst = 1'b0;
    cyc(3);
    check("post_rst_idle_gnt", 32'(b0.gnt), 32'h0);
    check("post_rst_idle_busy", 32'(b0.busy), 32'h0);

    // Wrap and early release: bring ptr to 14 via a short grant of 13.
    req_v[0] = 16'h2000;
    cyc(1);
    check("wrap_pre", 32'(b0.gnt), 32'h2000);
    req_v[0] = '0;
    cyc(4);
    req_v[0] = 16'h4003;
    cyc(1);
    check("wrap_own14", 32'(b0.gnt), 32'h4000);
    cyc(2);
    req_v[0] = 16'h0003;
    cyc(1);
    check("wrap_release", 32'(b0.gnt), 32'h0);
    check("wrap_release_el", 32'(b0.el), 32'h1);
    cyc(1);
    check("wrap_own0", 32'(b0.gnt), 32'h0001);
    cyc(8);
    check("wrap_gap", 32'(b0.gnt), 32'h0);
    cyc(1);
    check("wrap_own1", 32'(b0.gnt), 32'h0002);
    req_v[0] = '0;
    cyc(4);

    // Enable gating.
    en_v[0]  = 1'b0;
    req_v[0] = 16'h0100;
    cyc(3);
    check("en0_gnt", 32'(b0.gnt), 32'h0);
    check("en0_busy", 32'(b0.busy), 32'h0);
    en_v[0] = 1'b1;
    cyc(1);
    check("en1_gnt", 32'(b0.gnt), 32'h0100);
    cyc(2);
    en_v[0] = 1'b0;
    cyc(5);
    check("en_off_beat8", 32'(b0.gnt), 32'h0100);
    cyc(1);
    check("en_off_gap_gnt", 32'(b0.gnt), 32'h0);
    check("en_off_gap_busy", 32'(b0.busy), 32'h1);
    cyc(1);
    check("en_off_idle", 32'(b0.busy), 32'h0);
    cyc(2);
    check("en_off_stay", 32'(b0.gnt), 32'h0);
    req_v[0] = '0;
    en_v[0]  = 1'b1;

    // Round-robin rotation with 2-beat bursts.
    req_v[1] = 16'hFFFF;
    cyc(1);
    check("rr_own0", 32'(b1.gnt), 32'h0001);
    for (int o = 1; o <= 16; o++) begin
      logic [15:0] e;
      cyc(2);
      check($sformatf("rr_gap%0d", o), {31'b0, b1.el}, 32'h1);
      cyc(1);
      e = 16'h0001 << (o % 16);
      check($sformatf("rr_own%0d", o % 16), 32'(b1.gnt), 32'(e));
    end
    req_v[1] = '0;
    cyc(4);

    // Zero gap, no preemption, back-to-back handover.
    req_v[2] = 16'h0011;
    cyc(1);
    check("zg_own0", 32'(b2.gnt), 32'h0001);
    cyc(2);
    req_v[2] = 16'h0015;
    cyc(5);
    check("zg_own0_beat8", 32'(b2.gnt), 32'h0001);
    cyc(1);
    check("zg_own2", 32'(b2.gnt), 32'h0004);
    check("zg_own2_el", 32'(b2.el), 32'h0);
    cyc(8);
    check("zg_own4", 32'(b2.gnt), 32'h0010);
    check("zg_own4_sel", 32'(b2.sel), 32'h4);
    req_v[2] = '0;
    cyc(3);
    check("zg_idle", 32'(b2.busy), 32'h0);

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mux16_rr_sched.md
Name: mux16_rr_sched

Overview:
Round-robin scheduler that shares the 16:1 mux/bus-driver datapath between 16 requesters.
It drives the mux select and active-low mux enable (el: 0 = mux drives, 1 = output high-Z), and returns a one-hot grant to the winning requester.
Each ownership lasts a bounded burst and is followed by a programmable high-Z turnaround gap, so that downstream bus drivers never overlap.

Parameters:
MAX_BEATS, 8, maximum consecutive cycles one requester may own the mux (legal range 1..255).
GAP_CYCLES, 1, high-Z turnaround cycles after every grant ends (legal range 0..15).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous reset, active-high.
en  input  1  scheduler enable; 0 blocks new grants, and a grant in progress completes normally.
req  input  16  request per mux input; requester i holds req[i] high while it needs the mux.
gnt  output  16  one-hot grant, registered; all-zero when no owner.
sel  output  4  mux select, registered; equals the owner index while granted.
el  output  1  active-low mux enable, registered; 0 only while gnt is non-zero.
busy  output  1  high in GRANT or GAP state.

Behaviour:
- Reset (asynchronous, immediate):
  - Outputs: gnt=0, sel=0, el=1, busy=0.
  - Internal state: state=IDLE, rr pointer ptr=0, beat counter=0, gap counter=0.
  - Reset mid-grant drops gnt and forces el=1 without waiting for a clock edge.
- States: IDLE, GRANT, GAP. All outputs are registered; there are no combinational paths from req to outputs.
- Arbitration (evaluated in IDLE, and on the final GAP cycle):
  - Condition: en=1 and req!=0.
  - Winner is the first set req bit at index ptr, ptr+1, … with modulo-16 wrap-around (15 -> 0).
  - At the next edge: state=GRANT, gnt=one-hot(winner), sel=winner, el=0, busy=1, beat=1.
- Latency: 1 cycle from req sampled high to gnt/el asserted.
- GRANT, evaluated at each edge:
  - If req[owner]=0, or beat==MAX_BEATS: grant ends.
  - Otherwise beat increments.
  - Consequence: gnt is held for at most MAX_BEATS cycles, and for exactly MAX_BEATS cycles if req stays high.
- Grant end, at the same edge:
  - gnt=0, el=1, sel holds the owner index, ptr=owner+1 mod 16.
  - If GAP_CYCLES>0: state=GAP, gap counter=1.
  - If GAP_CYCLES=0: arbitration is evaluated immediately, giving back-to-back grants with el re-asserted at that edge. A new winner gets gnt/sel at the same edge, with no el=1 cycle.
- GAP:
  - el=1, gnt=0, busy=1 for exactly GAP_CYCLES cycles.
  - On the last gap cycle, arbitrate. With no eligible request, go to IDLE and set busy=0.
- Other requests arriving or dropping during GRANT never preempt the owner.
- A requester re-asserting after its grant ends competes at lowest priority, because ptr has moved past it.
- en=0:
  - IDLE stays IDLE.
  - A GRANT in progress runs to its normal end.
  - GAP completes, then goes to IDLE.
- Invariants:
  - popcount(gnt) ≤ 1.
  - el==0 iff gnt!=0.
  - When gnt!=0, gnt[sel]=1.

Test Plan:
- Reset: assert rst mid-grant (owner 5, beat 3) → gnt=0, el=1, busy=0, sel=0 before the next clk edge; after release with req=0 the block stays IDLE.
- Single long request: MAX_BEATS=8, GAP_CYCLES=1, req=0x0008 held → gnt=0x0008, sel=3, el=0 one cycle after req, held exactly 8 cycles, then 1 cycle el=1, then re-granted to 3 (sole requester).
- Round-robin rotation: req=0xFFFF held, MAX_BEATS=2, GAP_CYCLES=1 → owners 0,1,2,…,15,0 in order; each gnt lasts 2 cycles, separated by 1 high-Z cycle.
- Wrap and early release: ptr=14, req=0x0003|0x4000 → owner 14; drop req[14] after 3 cycles → gnt ends at that edge, then owners 0 then 1.
- Zero gap and no preemption: GAP_CYCLES=0, req=0x0011 → owner 0 for 8 cycles; raising req[2] mid-grant has no effect; next edge gives gnt=0x0004, then 0x0010, with el never 1 between grants.
- Enable gating: en=0 with req=0x0100 → no grant, busy=0; en=1 → gnt=0x0100 one cycle later; deassert en mid-grant → grant completes its 8 beats, gap runs, then IDLE.
